// File: rtl/alu_arbiter_if.sv
// Requester-side bus of alu_arbiter: two request ports and one tagged response channel.
interface alu_arbiter_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CTRL_W = 3
);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [WIDTH-1:0]  req0_a;
    logic [WIDTH-1:0]  req0_b;
    logic [CTRL_W-1:0] req0_ctrl;
    logic [WIDTH-1:0]  req1_a;
    logic [WIDTH-1:0]  req1_b;
    logic [CTRL_W-1:0] req1_ctrl;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [WIDTH-1:0]  rsp_data;
    logic              rsp_ovf;

    // Requester side: issues operations and consumes responses.
    modport master (
        output req_valid, req0_a, req0_b, req0_ctrl, req1_a, req1_b, req1_ctrl, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_ovf
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req0_a, req0_b, req0_ctrl, req1_a, req1_b, req1_ctrl, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_ovf
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands of the winner are latched onto the ALU ports, the result is
// registered and returned on a valid/ready channel tagged with the requester ID.
// Optional: define ALU_ARB_OVF_EN to compute the signed-overflow flag rsp_ovf
// for add/sub; otherwise rsp_ovf is tied to 0.
module alu_arbiter #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CTRL_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    alu_arbiter_if.slave      bus,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_result
);
    localparam int unsigned MSB = WIDTH - 1;
    localparam logic [CTRL_W-1:0] CTRL_ADD = CTRL_W'(0);
    localparam logic [CTRL_W-1:0] CTRL_SUB = CTRL_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [CTRL_W-1:0] op_ctrl;
    logic              grant_id;
    logic              last_grant;
    logic              rsp_valid_q;
    logic              rsp_id_q;
    logic [WIDTH-1:0]  rsp_data_q;
    logic              rsp_ovf_q;
    logic              winner_c;
    logic              accept_c;
    logic [1:0]        req_ready_c;
    logic              ovf_c;

    assign alu_a    = op_a;
    assign alu_b    = op_b;
    assign alu_ctrl = op_ctrl;

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_ovf   = rsp_ovf_q;

`ifdef ALU_ARB_OVF_EN
    // Signed overflow of the current add/sub, judged from operand and result sign bits.
    always_comb begin
        ovf_c = 1'b0;
        if (op_ctrl == CTRL_ADD) begin
            ovf_c = (op_a[MSB] == op_b[MSB]) && (alu_result[MSB] != op_a[MSB]);
        end else if (op_ctrl == CTRL_SUB) begin
            ovf_c = (op_a[MSB] != op_b[MSB]) && (alu_result[MSB] != op_a[MSB]);
        end
    end
`else
    assign ovf_c = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, round-robin winner and request accept.
    always_comb begin
        state_d     = state_q;
        req_ready_c = 2'b00;
        accept_c    = 1'b0;
        if (bus.req_valid == 2'b11) begin
            winner_c = ~last_grant;
        end else begin
            winner_c = bus.req_valid[1];
        end
        case (state_q)
            IDLE: begin
                if (bus.req_valid != 2'b00) begin
                    accept_c    = 1'b1;
                    req_ready_c = winner_c ? 2'b10 : 2'b01;
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand latch, result capture and response channel registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_a        <= '0;
            op_b        <= '0;
            op_ctrl     <= '0;
            grant_id    <= 1'b0;
            last_grant  <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        grant_id <= winner_c;
                        if (winner_c) begin
                            op_a    <= bus.req1_a;
                            op_b    <= bus.req1_b;
                            op_ctrl <= bus.req1_ctrl;
                        end else begin
                            op_a    <= bus.req0_a;
                            op_b    <= bus.req0_b;
                            op_ctrl <= bus.req0_ctrl;
                        end
                    end
                end
                EXEC: begin
                    rsp_data_q  <= alu_result;
                    rsp_id_q    <= grant_id;
                    rsp_ovf_q   <= ovf_c;
                    rsp_valid_q <= 1'b1;
                    last_grant  <= grant_id;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 32-bit ALU (ctrl 000 add, 001 sub, 010 or, 011 and, other codes give 0) between two requesters.
- The block arbitrates round-robin and latches the winner's operands into the ALU operand ports.
- It captures the ALU result in a register and returns it to the requester through a valid/ready response channel tagged with the requester ID.
- It sits between the datapath stages that issue ALU work and the single ALU instance.

Parameters:
- WIDTH, 32, operand and result width (must match the ALU).
- CTRL_W, 3, ALU control code width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- req_valid  input  2  per-requester request valid (bit i = requester i).
- req_ready  output  2  per-requester request accept.
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req0_ctrl  input  CTRL_W  requester 0 ALU op.
- req1_a  input  WIDTH  requester 1 operand A.
- req1_b  input  WIDTH  requester 1 operand B.
- req1_ctrl  input  CTRL_W  requester 1 ALU op.
- alu_a  output  WIDTH  to ALU input A.
- alu_b  output  WIDTH  to ALU input B.
- alu_ctrl  output  CTRL_W  to ALU control.
- alu_result  input  WIDTH  from ALU result.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accept.
- rsp_id  output  1  requester ID of the response.
- rsp_data  output  WIDTH  registered ALU result.
- rsp_ovf  output  1  signed overflow flag (see Optional Feature).

Behaviour:
- Reset (reset==0 at a clk edge) applies regardless of state, including mid-operation. A pending request is dropped and not responded to.
  - state=IDLE.
  - Operand regs op_a, op_b = 0; op_ctrl = 3'b000.
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_ovf=0.
  - last_grant=1, so requester 0 wins the first contention.
- alu_a, alu_b and alu_ctrl are driven directly from op_a, op_b and op_ctrl in all states, so they read 0/0/000 after reset.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational: req_ready[i] = 1 only when state==IDLE, req_valid[i]==1 and i is the arbitration winner. At most one bit is set.
  - Arbitration with one valid: that requester wins.
  - Arbitration with both valid: the requester not equal to last_grant wins.
  - On an accept (req_valid[i]&&req_ready[i]): latch that requester's a, b, ctrl into op regs; record grant_id=i; go to EXEC.
  - With no valid request, stay in IDLE; op regs hold their values.
- EXEC (exactly one cycle):
  - Register rsp_data<=alu_result and rsp_id<=grant_id.
  - Set rsp_valid<=1.
  - Set last_grant<=grant_id.
  - Go to RESP.
  - req_ready=0.
- RESP:
  - rsp_valid, rsp_id, rsp_data and rsp_ovf are held stable until rsp_ready==1.
  - On handshake: rsp_valid<=0 and go to IDLE.
  - req_ready=0 throughout RESP.
  - No new accept happens in the handshake cycle; the earliest next accept is the following cycle.
- Latency: accept at edge T, rsp_valid high after edge T+1. With rsp_ready held high, throughput is one operation per 3 cycles.
- Arithmetic:
  - Add and sub wrap modulo 2^WIDTH (e.g., FFFFFFFF+1=00000000).
  - Unsupported ctrl codes are passed through unchanged; the response is 0 as produced by the ALU.
- Requesters must hold a, b, ctrl stable while req_valid is high and not yet accepted. A requester may drop req_valid before acceptance.
- Fairness: under continuous contention, grants alternate 0,1,0,1...

Optional Feature:
- Macro ALU_ARB_OVF_EN.
- Defined: in EXEC, rsp_ovf<=1 when either condition holds; otherwise rsp_ovf<=0.
  - op_ctrl==000 and op_a[WIDTH-1]==op_b[WIDTH-1]!=alu_result[WIDTH-1].
  - op_ctrl==001 and op_a[WIDTH-1]!=op_b[WIDTH-1] and alu_result[WIDTH-1]!=op_a[WIDTH-1].
- rsp_ovf is held with the response and cleared by reset.
- Not defined: rsp_ovf is constant 0. The port remains present.

Test Plan:
- Single request: reset release; req_valid=01, req0=(5,3,000) -> req_ready=01 same cycle; rsp_valid=1, rsp_id=0, rsp_data=8 two edges later; rsp_ready=1 -> back to IDLE.
- Contention: both valid continuously, req0=(7,2,001), req1=(F0,0F,010), rsp_ready=1 -> responses in order id0=5, id1=FF, id0=5, id1=FF; each accept 3 cycles apart.
- Backpressure: req1=(C,A,011), rsp_ready=0 for 5 cycles -> rsp_valid, rsp_id=1, rsp_data=8 stable; req_ready=00 throughout; rsp_ready=1 -> IDLE next cycle.
- Wrap and default: req0=(FFFFFFFF,1,000) -> rsp_data=0; req0=(9,9,111) -> rsp_data=0.
- Reset mid-operation: reset=0 during RESP -> next edge rsp_valid=0, alu_a=0, state IDLE; then both valid -> requester 0 wins.
- Overflow (ALU_ARB_OVF_EN defined): (7FFFFFFF,1,000) -> rsp_data=80000000, rsp_ovf=1; (80000000,1,001) -> rsp_ovf=1. Macro undefined -> rsp_ovf=0 for the same stimuli.
